// File: rtl/mips_inst_encoder_pkg.sv
// Shared MIPS encoding constants: opcodes, funct codes, mnemonic indices and field payload.
package mips_inst_encoder_pkg;

  localparam int unsigned MNEM_W     = 6;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned TGT_W      = 26;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned MNEM_COUNT = 35;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                              OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                              OP_SLTI  = 6'h0a, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d,
                              OP_LUI   = 6'h0f, OP_LB   = 6'h20, OP_LH   = 6'h21,
                              OP_LW    = 6'h23, OP_LBU  = 6'h24, OP_LHU  = 6'h25,
                              OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2b;

  localparam logic [OP_W-1:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
                              F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                              F_JR   = 6'h08, F_JALR = 6'h09, F_ADD  = 6'h20,
                              F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
                              F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26,
                              F_NOR  = 6'h27, F_SLT  = 6'h2a, F_SLTU = 6'h2b;

  localparam logic [MNEM_W-1:0]
    MN_ADD  = 6'd0,  MN_SUB  = 6'd1,  MN_AND  = 6'd2,  MN_OR   = 6'd3,  MN_SLT  = 6'd4,
    MN_SLTU = 6'd5,  MN_ADDU = 6'd6,  MN_SUBU = 6'd7,  MN_SLL  = 6'd8,  MN_SRL  = 6'd9,
    MN_SLLV = 6'd10, MN_SRLV = 6'd11, MN_NOR  = 6'd12, MN_JR   = 6'd13, MN_JALR = 6'd14,
    MN_XOR  = 6'd15, MN_SRA  = 6'd16, MN_SRAV = 6'd17, MN_ADDI = 6'd18, MN_ORI  = 6'd19,
    MN_LW   = 6'd20, MN_SW   = 6'd21, MN_BEQ  = 6'd22, MN_BNE  = 6'd23, MN_SLTI = 6'd24,
    MN_LUI  = 6'd25, MN_ANDI = 6'd26, MN_LB   = 6'd27, MN_LH   = 6'd28, MN_LBU  = 6'd29,
    MN_LHU  = 6'd30, MN_SB   = 6'd31, MN_SH   = 6'd32, MN_J    = 6'd33, MN_JAL  = 6'd34;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILL} fmt_t;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [IMM_W-1:0] imm;
    logic [TGT_W-1:0] target;
  } mips_fields_t;

endpackage

// File: rtl/mips_field_pack.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, with field masking per format.
module mips_field_pack
  import mips_inst_encoder_pkg::*;
(
  input  logic [MNEM_W-1:0]  mnem,
  input  mips_fields_t       fields,
  output logic [INSTR_W-1:0] instr,
  output logic               illegal
);

  fmt_t             fmt;
  logic [OP_W-1:0]  op;
  logic [OP_W-1:0]  funct;
  logic [REG_W-1:0] rs, rt, rd, shamt;

  // Format/opcode selection; shamt only survives for immediate shifts
  always_comb begin
    fmt   = FMT_ILL;
    op    = OP_RTYPE;
    funct = '0;
    rs    = fields.rs;
    rt    = fields.rt;
    rd    = fields.rd;
    shamt = '0;
    case (mnem)
      MN_ADD:  begin fmt = FMT_R; funct = F_ADD;  end
      MN_SUB:  begin fmt = FMT_R; funct = F_SUB;  end
      MN_AND:  begin fmt = FMT_R; funct = F_AND;  end
      MN_OR:   begin fmt = FMT_R; funct = F_OR;   end
      MN_SLT:  begin fmt = FMT_R; funct = F_SLT;  end
      MN_SLTU: begin fmt = FMT_R; funct = F_SLTU; end
      MN_ADDU: begin fmt = FMT_R; funct = F_ADDU; end
      MN_SUBU: begin fmt = FMT_R; funct = F_SUBU; end
      MN_SLL:  begin fmt = FMT_R; funct = F_SLL; rs = '0; shamt = fields.shamt; end
      MN_SRL:  begin fmt = FMT_R; funct = F_SRL; rs = '0; shamt = fields.shamt; end
      MN_SRA:  begin fmt = FMT_R; funct = F_SRA; rs = '0; shamt = fields.shamt; end
      MN_SLLV: begin fmt = FMT_R; funct = F_SLLV; end
      MN_SRLV: begin fmt = FMT_R; funct = F_SRLV; end
      MN_SRAV: begin fmt = FMT_R; funct = F_SRAV; end
      MN_NOR:  begin fmt = FMT_R; funct = F_NOR;  end
      MN_XOR:  begin fmt = FMT_R; funct = F_XOR;  end
      MN_JR:   begin fmt = FMT_R; funct = F_JR;   rt = '0; rd = '0; end
      MN_JALR: begin fmt = FMT_R; funct = F_JALR; rt = '0; end
      MN_ADDI: begin fmt = FMT_I; op = OP_ADDI; end
      MN_ORI:  begin fmt = FMT_I; op = OP_ORI;  end
      MN_LW:   begin fmt = FMT_I; op = OP_LW;   end
      MN_SW:   begin fmt = FMT_I; op = OP_SW;   end
      MN_BEQ:  begin fmt = FMT_I; op = OP_BEQ;  end
      MN_BNE:  begin fmt = FMT_I; op = OP_BNE;  end
      MN_SLTI: begin fmt = FMT_I; op = OP_SLTI; end
      MN_LUI:  begin fmt = FMT_I; op = OP_LUI; rs = '0; end
      MN_ANDI: begin fmt = FMT_I; op = OP_ANDI; end
      MN_LB:   begin fmt = FMT_I; op = OP_LB;   end
      MN_LH:   begin fmt = FMT_I; op = OP_LH;   end
      MN_LBU:  begin fmt = FMT_I; op = OP_LBU;  end
      MN_LHU:  begin fmt = FMT_I; op = OP_LHU;  end
      MN_SB:   begin fmt = FMT_I; op = OP_SB;   end
      MN_SH:   begin fmt = FMT_I; op = OP_SH;   end
      MN_J:    begin fmt = FMT_J; op = OP_J;    end
      MN_JAL:  begin fmt = FMT_J; op = OP_JAL;  end
      default: fmt = FMT_ILL;
    endcase
  end

  // Field assembly; unsupported mnemonics become a nop
  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R:   instr = {OP_RTYPE, rs, rt, rd, shamt, funct};
      FMT_I:   instr = {op, rs, rt, fields.imm};
      FMT_J:   instr = {op, fields.target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// Streaming MIPS encoder: one-entry registered output stage, word address counter, illegal counter.
module mips_inst_encoder
  import mips_inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               restart,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MNEM_W-1:0]  in_mnem,
  input  logic [REG_W-1:0]   in_rs,
  input  logic [REG_W-1:0]   in_rt,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [REG_W-1:0]   in_shamt,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic [TGT_W-1:0]   in_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt,
  output logic               wrapped
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  mips_fields_t       fields;
  logic [INSTR_W-1:0] pk_instr;
  logic               pk_illegal;
  logic [ADDR_W-1:0]  addr_cnt;
  logic               accept;

  assign fields = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                    imm: in_imm, target: in_target};

  mips_field_pack u_pack (
    .mnem    (in_mnem),
    .fields  (fields),
    .instr   (pk_instr),
    .illegal (pk_illegal)
  );

  assign in_ready = ~restart & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Output register, address counter, wrap flag and saturating illegal counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_addr    <= BASE;
      out_illegal <= 1'b0;
      illegal_cnt <= '0;
      wrapped     <= 1'b0;
      addr_cnt    <= BASE;
    end else if (restart) begin
      out_valid <= 1'b0;
      wrapped   <= 1'b0;
      addr_cnt  <= BASE;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_instr   <= pk_instr;
      out_illegal <= pk_illegal;
      out_addr    <= addr_cnt;
      addr_cnt    <= addr_cnt + ADDR_W'(1);
      if (&addr_cnt) wrapped <= 1'b1;
      if (pk_illegal && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mips_inst_encoder.md
Name: mips_inst_encoder

Overview:
- Streaming instruction encoder: the inverse of the control decoder.
- Accepts a mnemonic index plus operand fields and emits the 32-bit MIPS machine word, tagged with a sequential instruction-memory word address.
- Sits between the testbench/program loader and the instruction-memory write port, so programs can be built from fields instead of hand-assembled hex.
- One-entry registered output stage with valid/ready on both sides; also counts illegal mnemonics.

Parameters:
ADDR_W, 8, width of instruction-memory word address (out_addr wraps at 2^ADDR_W)
BASE_ADDR, 0, address loaded into the address counter at reset and on restart

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
restart  in  1  synchronous pulse: address counter <= BASE_ADDR, output entry dropped
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept this cycle
in_mnem  in  6  mnemonic index (package enumeration)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shift amount
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target field
out_valid  out  1  out_instr/out_addr valid
out_ready  in  1  downstream accepts
out_instr  out  32  encoded machine word
out_addr  out  ADDR_W  word address assigned to out_instr
out_illegal  out  1  in_mnem was not a supported mnemonic
illegal_cnt  out  8  saturating count of accepted illegal mnemonics
wrapped  out  1  sticky: address counter has wrapped since reset/restart

Behaviour:
- Reset (rstn low, asynchronous):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_illegal=0, illegal_cnt=0, wrapped=0.
  - Internal addr counter = BASE_ADDR.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational; no bubble under continuous ready).
  - Accept when in_valid & in_ready.
  - Latency 1 cycle: the accepted word appears on out_* the next cycle with out_valid=1.
  - out_* hold stable while out_valid & ~out_ready.
  - out_valid falls after a handshake unless a new accept happens in the same cycle.
- Address:
  - On accept, out_addr <= counter; counter <= counter+1 modulo 2^ADDR_W.
  - At the transition from 2^ADDR_W-1 to 0, set wrapped=1.
- restart:
  - Highest priority over any accept in the same cycle.
  - Actions: counter=BASE_ADDR, out_valid=0, wrapped=0; illegal_cnt is kept.
  - in_ready is forced 0 while restart is high.
- Mnemonic map: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu, 6 addu, 7 subu, 8 sll, 9 srl, 10 sllv, 11 srlv, 12 nor, 13 jr, 14 jalr, 15 xor, 16 sra, 17 srav, 18 addi, 19 ori, 20 lw, 21 sw, 22 beq, 23 bne, 24 slti, 25 lui, 26 andi, 27 lb, 28 lh, 29 lbu, 30 lhu, 31 sb, 32 sh, 33 j, 34 jal.
- Encoding rules:
  - R-type: op=0, {rs,rt,rd,shamt,funct}.
    - shamt forced 0 except for sll/srl/sra.
    - sll/srl/sra: rs forced 0.
    - jr: rt, rd, shamt forced 0.
    - jalr: rt and shamt forced 0; rd taken as given.
  - I-type: {op,rs,rt,imm}; lui forces rs=0.
  - J-type: {op,target}.
- Illegal mnem (35..63):
  - out_instr=0x00000000 (nop), out_illegal=1.
  - illegal_cnt increments on accept and saturates at 255.
  - The address is still consumed.

Decomposition:
- Shared package, also used by the decoder:
  - opcode and funct localparams.
  - Mnemonic enumeration constants.
  - Mnemonic count (35).
- One natural combinational sub-module, mips_field_pack:
  - Inputs: mnem and fields.
  - Outputs: instr and illegal.
- The top holds the handshake register, address counter, wrap flag and illegal counter.

Test Plan:
- addi (18) rs=0 rt=8 imm=5, out_ready=1 -> next cycle out_valid=1, out_instr=0x20080005, out_addr=0, out_illegal=0.
- Back-to-back add (rs=1 rt=2 rd=3), lw (rs=1 rt=2 imm=4), beq (rs=1 rt=2 imm=0xFFFF), j (target=0x0100000), continuous ready -> 0x00221820, 0x8C220004, 0x1022FFFF, 0x08100000 on consecutive cycles, addrs 0..3.
- sll with rs=7 rt=3 rd=2 shamt=4 -> 0x00031100 (rs masked); add with shamt=9 -> shamt bits zero.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid held.
  - Required: in_ready=0 after the first accept; out_* stable; no address skipped when ready returns.
- ADDR_W=2, 5 accepts -> addrs 0,1,2,3,0 and wrapped=1 after the 4th; restart with in_valid=1 in the same cycle -> no accept, out_valid=0, next accept gets addr 0, wrapped=0.
- Illegal mnem=40 x 300 accepts -> out_instr=0, out_illegal=1, illegal_cnt saturates at 255; assert rstn low mid-stream -> all outputs at reset values immediately.
